mbist_march_sequencer: RTL and testbench
========================================

// Module: mbist_march_sequencer
// PURPOSE
//  Runs a March C- self-test on the word-addressed RAM in front of mbisr_controller.
//  Drives the RAM port directly while testing. Streams every miscompare address as a
//  one-cycle fail pulse into mbisr_controller (bist_fail_valid/bist_fail_addr).
//  Reports busy/done/pass status. Hands the RAM back to the user path when idle.
// PARAMETERS
//  ADDR_WIDTH  8      RAM address width
//  DATA_WIDTH  8      RAM data width
//  TEST_DEPTH  240    words tested, addresses 0..TEST_DEPTH-1 (spare rows at 0xF0+ excluded); >=1
//  CNT_WIDTH   8      width of fail_count
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  rst         in   1           synchronous reset, active-high
//  start       in   1           begin a test run; sampled only in IDLE or DONE
//  abort       in   1           stop a run, return to IDLE
//  busy        out  1           1 in RUN/DRAIN; user path must be muxed off RAM
//  done        out  1           1 in DONE
//  pass        out  1           valid with done: 1 = zero miscompares
//  fail_count  out  CNT_WIDTH   miscompares this run, saturating
//  fail_valid  out  1           one-cycle pulse per miscompare -> bist_fail_valid
//  fail_addr   out  ADDR_WIDTH  failing address, valid with fail_valid -> bist_fail_addr
//  mem_addr    out  ADDR_WIDTH  RAM address
//  mem_wdata   out  DATA_WIDTH  RAM write data
//  mem_we      out  1           RAM write enable
//  mem_en      out  1           RAM enable
//  mem_rdata   in   DATA_WIDTH  RAM read data, valid the cycle after a read is issued
// BEHAVIOUR
//  Reset values (also after rst mid-run):
//  - state=IDLE; all outputs 0.
//  - fail_count is cleared, no fail pulse is emitted.
//  - A reset does not clear mbisr_controller; its own rst does that.
//  FSM: IDLE -> RUN -> DRAIN -> DONE.
//  - IDLE->RUN on start.
//  - DONE->RUN on start; clears fail_count and pass.
//  - start is ignored in RUN and DRAIN.
//  - abort in RUN or DRAIN -> IDLE next cycle: outputs 0, done stays 0, in-flight compare dropped.
//  - abort in IDLE or DONE is ignored.
//  - abort has priority over start in the same cycle.
//  March elements, N=TEST_DEPTH; 0 = all-zeros word, 1 = all-ones word:
//  - M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 down r0.
//  - up = 0..N-1; down = N-1..0.
//  - All ops of one element finish at one address before the address steps.
//  - The address counter wraps cleanly between elements: up end N-1 -> down start N-1.
//  RUN timing:
//  - Exactly one RAM op per cycle, mem_en=1 every RUN cycle; no idle bubbles.
//  - RUN lasts 10N cycles. The first op (M0 w0 @0) is on the cycle after start is sampled.
//  - Read op: mem_we=0, expected value and address registered.
//  - Next cycle: compare mem_rdata to the expected value.
//  - On mismatch: fail_valid=1 and fail_addr=the read address, in that same compare cycle.
//  - fail_count increments by 1, saturating at 2^CNT_WIDTH-1.
//  - The same address may fail in several elements; each is pulsed, dedup is done downstream.
//  - The compare of a read overlaps the next op; a write op never produces a compare.
//  DRAIN:
//  - One cycle, mem_en=0; the compare for the final M5 read happens here.
//  - Then DONE.
//  Run latency: start sampled at cycle 0 -> ops on cycles 1..10N -> DRAIN at 10N+1 -> done=1 from 10N+2.
//  DONE:
//  - done=1; pass=(fail_count==0).
//  - Both held, with fail_count, until start, abort-irrelevant, or rst.
//  - RAM outputs are 0.
//  Outside RUN: mem_en=mem_we=0, mem_addr=mem_wdata=0, fail_valid=0.
// TESTING (TEST_DEPTH=4 unless noted)
//  1) Clean RAM, start pulse at cycle 0 -> 40 RUN cycles, busy 1..41, done=1 at 42, pass=1, fail_count=0, no fail_valid.
//  2) Bit0 stuck-at-0 @addr 2 -> exactly 2 fail pulses with fail_addr=2 (M2 r1, M4 r1); done, pass=0, fail_count=2.
//  3) Stuck-at-1 word @addr 0 -> fail pulses @0 in M1, M3, M5 (3 pulses); final pulse appears in the DRAIN cycle.
//  4) Sequence start at cycle 0, start again at cycle 10 -> second start ignored, run ends on schedule.
//     Then abort at cycle 20 -> IDLE at 21, done never 1.
//  5) rst high mid-M3 -> next cycle all outputs 0, state IDLE.
//     A new start then gives a full 40-cycle run from a cleared fail_count.
//  6) CNT_WIDTH=2, all words stuck-at-0 -> fail_count saturates at 3.
//     fail_valid still pulses for every miscompare (8 pulses); pass=0.

Source files
------------

// File: rtl/mbist_march_sequencer.sv
// March C- memory self-test sequencer: owns the RAM port while busy, streams every
// miscompare address as a one-cycle pulse and reports done/pass with a saturating fail count.
module mbist_march_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TEST_DEPTH = 240,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  fail_valid,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TEST_DEPTH - 1);
    localparam logic [2:0]            LAST_ELEM = 3'd5;

    state_t                  state_reg, state_next;
    logic [2:0]              elem_reg, elem_next;
    logic                    op_reg, op_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    cmp_pending_reg, cmp_pending_next;
    logic                    cmp_exp_reg, cmp_exp_next;
    logic [ADDR_WIDTH-1:0]   cmp_addr_reg, cmp_addr_next;
    logic [CNT_WIDTH-1:0]    fail_count_reg, fail_count_next;

    logic                    op_read;
    logic                    op_bit;
    logic                    elem_down;
    logic                    last_op;
    logic                    at_end;
    logic                    mismatch;
    logic [DATA_WIDTH-1:0]   pattern_word;
    logic [DATA_WIDTH-1:0]   expect_word;

    // Data words are a single bit replicated across the bus (0 = all-zeros, 1 = all-ones).
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_word
            assign pattern_word[gi] = op_bit;
            assign expect_word[gi]  = cmp_exp_reg;
        end
    endgenerate

    // Element op table: M0 w0 | M1 r0,w1 | M2 r1,w0 | M3 r0,w1 | M4 r1,w0 | M5 r0
    always_comb begin
        op_read = 1'b0;
        op_bit  = 1'b0;
        case (elem_reg)
            3'd0:    begin op_read = 1'b0;    op_bit = 1'b0;    end
            3'd1:    begin op_read = !op_reg; op_bit = op_reg;  end
            3'd2:    begin op_read = !op_reg; op_bit = !op_reg; end
            3'd3:    begin op_read = !op_reg; op_bit = op_reg;  end
            3'd4:    begin op_read = !op_reg; op_bit = !op_reg; end
            default: begin op_read = 1'b1;    op_bit = 1'b0;    end
        endcase
    end

    assign elem_down = (elem_reg >= 3'd3);
    assign last_op   = (elem_reg == 3'd0) || (elem_reg == LAST_ELEM) || op_reg;
    assign at_end    = elem_down ? (addr_reg == '0) : (addr_reg == LAST_ADDR);
    assign mismatch  = cmp_pending_reg && (mem_rdata != expect_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            elem_reg        <= '0;
            op_reg          <= 1'b0;
            addr_reg        <= '0;
            cmp_pending_reg <= 1'b0;
            cmp_exp_reg     <= 1'b0;
            cmp_addr_reg    <= '0;
            fail_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            elem_reg        <= elem_next;
            op_reg          <= op_next;
            addr_reg        <= addr_next;
            cmp_pending_reg <= cmp_pending_next;
            cmp_exp_reg     <= cmp_exp_next;
            cmp_addr_reg    <= cmp_addr_next;
            fail_count_reg  <= fail_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        elem_next        = elem_reg;
        op_next          = op_reg;
        addr_next        = addr_reg;
        cmp_pending_next = 1'b0;
        cmp_exp_next     = cmp_exp_reg;
        cmp_addr_next    = cmp_addr_reg;
        fail_count_next  = fail_count_reg;
        busy             = 1'b0;
        done             = 1'b0;
        pass             = 1'b0;
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        fail_valid       = mismatch;
        fail_addr        = mismatch ? cmp_addr_reg : '0;

        if (mismatch && (fail_count_reg != '1))
            fail_count_next = fail_count_reg + CNT_WIDTH'(1);

        case (state_reg)
            S_IDLE, S_DONE: begin
                done = (state_reg == S_DONE);
                pass = done && (fail_count_reg == '0);
                if (start && !abort) begin
                    state_next      = S_RUN;
                    elem_next       = '0;
                    op_next         = 1'b0;
                    addr_next       = '0;
                    fail_count_next = '0;
                end
            end
            S_RUN: begin
                busy             = 1'b1;
                mem_en           = 1'b1;
                mem_we           = !op_read;
                mem_addr         = addr_reg;
                mem_wdata        = op_read ? '0 : pattern_word;
                cmp_pending_next = op_read;
                cmp_exp_next     = op_bit;
                cmp_addr_next    = addr_reg;
                if (!last_op) begin
                    op_next = 1'b1;
                end else begin
                    op_next = 1'b0;
                    if (!at_end) begin
                        addr_next = elem_down ? addr_reg - ADDR_WIDTH'(1) : addr_reg + ADDR_WIDTH'(1);
                    end else if (elem_reg == LAST_ELEM) begin
                        state_next = S_DRAIN;
                    end else begin
                        // Up elements end at N-1 and the first down element starts there too.
                        elem_next = elem_reg + 3'd1;
                        addr_next = (elem_reg >= 3'd2) ? LAST_ADDR : '0;
                    end
                end
            end
            S_DRAIN: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase

        // Abort drops any in-flight compare and leaves nothing visible in IDLE.
        if (abort && (state_reg == S_RUN || state_reg == S_DRAIN)) begin
            state_next       = S_IDLE;
            cmp_pending_next = 1'b0;
            fail_count_next  = '0;
        end
    end

    assign fail_count = fail_count_reg;

endmodule

// File: tb/tb_mbist_march_sequencer.sv
// Scoreboard bench for mbist_march_sequencer with TEST_DEPTH=4: fault-injecting RAM models,
// expected fail pulses queued at stimulus time and popped by a negedge monitor.
module tb_mbist_march_sequencer;

    typedef struct {
        int addr;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: CNT_WIDTH=8
    logic       a_start = 1'b0, a_abort = 1'b0;
    logic       a_busy, a_done, a_pass, a_fail_valid, a_mem_we, a_mem_en;
    logic [7:0] a_fail_count, a_fail_addr, a_mem_addr, a_mem_wdata;
    logic [7:0] a_mem_rdata = '0;

    // DUT B: CNT_WIDTH=2
    logic       b_start = 1'b0, b_abort = 1'b0;
    logic       b_busy, b_done, b_pass, b_fail_valid, b_mem_we, b_mem_en;
    logic [1:0] b_fail_count;
    logic [7:0] b_fail_addr, b_mem_addr, b_mem_wdata;
    logic [7:0] b_mem_rdata = '0;

    mbist_march_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TEST_DEPTH(4), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done), .pass(a_pass), .fail_count(a_fail_count),
        .fail_valid(a_fail_valid), .fail_addr(a_fail_addr),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_en(a_mem_en), .mem_rdata(a_mem_rdata)
    );

    mbist_march_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TEST_DEPTH(4), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fail_count(b_fail_count),
        .fail_valid(b_fail_valid), .fail_addr(b_fail_addr),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_en(b_mem_en), .mem_rdata(b_mem_rdata)
    );

    // RAM models with stuck-at masks applied on the read path
    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    logic [7:0] sa0_a [256];
    logic [7:0] sa1_a [256];
    logic [7:0] sa0_b [256];

    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
            a_mem_rdata <= (ram_a[a_mem_addr] & ~sa0_a[a_mem_addr]) | sa1_a[a_mem_addr];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
            b_mem_rdata <= ram_b[b_mem_addr] & ~sa0_b[b_mem_addr];
        end
    end

    int   vectors = 0;
    int   miscompares = 0;
    int   t0_a = 0, t0_b = 0;
    int   en_a = 0, en_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_a(input int addr, input int c);
        exp_t e;
        e.addr = addr;
        e.cyc  = c;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int addr, input int c);
        exp_t e;
        e.addr = addr;
        e.cyc  = c;
        q_b.push_back(e);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin
            sa0_a[i] = '0;
            sa1_a[i] = '0;
            sa0_b[i] = '0;
        end
    endtask

    // Relative cycle 1 is the first RUN cycle (start sampled at the edge ending cycle 0).
    task automatic start_a();
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        t0_a = cyc - 1;
        en_a = 0;
    endtask

    task automatic start_b();
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        t0_b = cyc - 1;
        en_b = 0;
    endtask

    task automatic wait_a(input int n);
        @(negedge clk);
        while (cyc - t0_a < n) @(negedge clk);
    endtask

    task automatic wait_b(input int n);
        @(negedge clk);
        while (cyc - t0_b < n) @(negedge clk);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_ctl"}, {a_busy, a_done, a_pass, a_fail_valid, a_mem_en, a_mem_we}, 0);
        check({tag, "_fail_count"}, a_fail_count, 0);
        check({tag, "_bus"}, {a_fail_addr, a_mem_addr, a_mem_wdata}, 0);
    endtask

    task automatic check_done_a(input string tag, input int cnt);
        check({tag, "_done"}, a_done, 1);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_pass"}, a_pass, (cnt == 0) ? 1 : 0);
        check({tag, "_fail_count"}, a_fail_count, cnt);
        check({tag, "_op_cycles"}, en_a, 40);
        check({tag, "_pending_pulses"}, q_a.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        clear_faults();

        // Scoreboard monitor: pops one expectation per fail pulse
        fork
            forever begin
                @(negedge clk);
                if (a_mem_en) en_a++;
                if (b_mem_en) en_b++;
                if (a_fail_valid) begin
                    vectors++;
                    if (q_a.size() == 0) begin
                        miscompares++;
                        $display("FAIL pulse_a: got addr=%0d cyc=%0d, required no pulse", a_fail_addr, cyc - t0_a);
                    end else begin
                        exp_t e;
                        e = q_a.pop_front();
                        if (a_fail_addr != 8'(e.addr) || (cyc - t0_a) != e.cyc) begin
                            miscompares++;
                            $display("FAIL pulse_a: got addr=%0d cyc=%0d, required addr=%0d cyc=%0d",
                                     a_fail_addr, cyc - t0_a, e.addr, e.cyc);
                        end
                    end
                end
                if (b_fail_valid) begin
                    vectors++;
                    if (q_b.size() == 0) begin
                        miscompares++;
                        $display("FAIL pulse_b: got addr=%0d cyc=%0d, required no pulse", b_fail_addr, cyc - t0_b);
                    end else begin
                        exp_t e;
                        e = q_b.pop_front();
                        if (b_fail_addr != 8'(e.addr) || (cyc - t0_b) != e.cyc) begin
                            miscompares++;
                            $display("FAIL pulse_b: got addr=%0d cyc=%0d, required addr=%0d cyc=%0d",
                                     b_fail_addr, cyc - t0_b, e.addr, e.cyc);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_a("reset");
        check("reset_b_ctl", {b_busy, b_done, b_pass, b_fail_valid, b_mem_en, b_fail_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1) clean RAM
        start_a();
        check("t1_c1_busy", a_busy, 1);
        check("t1_c1_op", {a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}, {1'b1, 1'b1, 8'd0, 8'd0});
        wait_a(6);
        check("t1_c6_w1", {a_mem_we, a_mem_addr, a_mem_wdata}, {1'b1, 8'd0, 8'hFF});
        wait_a(20);
        check("t1_c20_m2_last", {a_mem_we, a_mem_addr}, {1'b1, 8'd3});
        wait_a(21);
        check("t1_c21_m3_first", {a_mem_we, a_mem_addr}, {1'b0, 8'd3});
        wait_a(40);
        check("t1_c40_m5_last", {a_mem_en, a_mem_we, a_mem_addr}, {1'b1, 1'b0, 8'd0});
        wait_a(41);
        check("t1_c41_drain", {a_busy, a_mem_en, a_done}, {1'b1, 1'b0, 1'b0});
        wait_a(42);
        check_done_a("t1", 0);

        // 2) bit0 stuck-at-0 at address 2 (start from DONE)
        sa0_a[2] = 8'h01;
        push_a(2, 18);
        push_a(2, 32);
        start_a();
        wait_a(19);
        check("t2_c19_count", a_fail_count, 1);
        wait_a(42);
        check_done_a("t2", 2);

        // 3) stuck-at-1 word at address 0; last pulse lands in DRAIN
        clear_faults();
        sa1_a[0] = 8'hFF;
        push_a(0, 6);
        push_a(0, 28);
        push_a(0, 41);
        start_a();
        check("t3_c1_count_cleared", {a_fail_count, a_pass, a_done}, 0);
        wait_a(41);
        check("t3_c41_drain_pulse", {a_busy, a_fail_valid, a_fail_addr}, {1'b1, 1'b1, 8'd0});
        wait_a(42);
        check_done_a("t3", 3);

        // 4) second start ignored; abort in DONE ignored; abort mid-run
        clear_faults();
        start_a();
        wait_a(10);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a(42);
        check_done_a("t4a", 0);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        check("t4_abort_in_done", {a_done, a_pass}, {1'b1, 1'b1});
        start_a();
        wait_a(20);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        check_idle_a("t4_c21_aborted");
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_done || a_busy) done_seen = 1;
        end
        check("t4_stays_idle", done_seen, 0);

        // 5) reset during M3, then a full run from a cleared count
        sa0_a[2] = 8'h01;
        push_a(2, 18);
        start_a();
        wait_a(24);
        check("t5_c24_count", {a_busy, a_fail_count}, {1'b1, 8'd1});
        rst = 1'b1;
        @(negedge clk);
        check_idle_a("t5_c25_reset");
        rst = 1'b0;
        @(negedge clk);
        push_a(2, 18);
        push_a(2, 32);
        start_a();
        check("t5_rerun_c1", {a_busy, a_fail_count}, {1'b1, 8'd0});
        wait_a(42);
        check_done_a("t5", 2);

        // 6) CNT_WIDTH=2, every word stuck-at-0: 8 pulses, count saturates at 3
        clear_faults();
        for (int i = 0; i < 4; i++) sa0_b[i] = 8'hFF;
        for (int a = 0; a < 4; a++) push_b(a, 14 + 2 * a);
        for (int a = 3; a >= 0; a--) push_b(a, 30 + 2 * (3 - a));
        start_b();
        wait_b(17);
        check("t6_c17_count", b_fail_count, 2);
        wait_b(19);
        check("t6_c19_count", b_fail_count, 3);
        wait_b(42);
        check("t6_done", {b_done, b_busy, b_pass}, {1'b1, 1'b0, 1'b0});
        check("t6_fail_count_sat", b_fail_count, 3);
        check("t6_op_cycles", en_b, 40);
        check("t6_pending_pulses", q_b.size(), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
